// File: rtl/past_sequence_recover_pkg.sv
// Shared parameter defaults for the past_sequence adder/recover pair, so both
// ends of a link are built from one parameter set.
package past_sequence_recover_pkg;

  localparam int DEFAULT_N  = 4;
  localparam int DEFAULT_DW = 8;

endpackage : past_sequence_recover_pkg

// File: rtl/past_sequence_recover_sample_history.sv
// N-deep, DW-wide sample shift register with shift-enable and synchronous clear.
// hist[0] is the newest entry, hist[N-1] the oldest.
module sample_history
  import past_sequence_recover_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int DW = DEFAULT_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_en,
  input  logic [DW-1:0]        din,
  output logic [N-1:0][DW-1:0] hist
);

  logic [N-1:0][DW-1:0] hist_q;
  logic [N-1:0][DW-1:0] hist_d;

  always_comb begin
    hist_d = hist_q;
    if (shift_en) begin
      hist_d[0] = din;
      for (int k = 1; k < N; k++) begin
        hist_d[k] = hist_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign hist = hist_q;

endmodule : sample_history

// File: rtl/past_sequence_recover.sv
// Reconstructs raw samples from a stream of N-sample window sums:
// x[t] = S[t] - S[t-1] + x[t-N], all modulo 2^DW.
module past_sequence_recover
  import past_sequence_recover_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int DW = DEFAULT_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] inp,
  output logic          out_valid,
  output logic [DW-1:0] outp,
  output logic          primed
);

  // Handshake: a sum is accepted on any rising edge with in_valid=1 and rst=0.
  // out_valid pulses for exactly one cycle per accepted sum; there is no ready,
  // the consumer must take every pulse.

  localparam int              CW       = $clog2(N + 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(N);

  logic [N-1:0][DW-1:0] hist;
  logic [DW-1:0]        x_now;

  logic [DW-1:0] s_prev_q, s_prev_d;
  logic [DW-1:0] outp_q,   outp_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          primed_q, primed_d;

  assign x_now = inp - s_prev_q + hist[N-1];

  sample_history #(
    .N  (N),
    .DW (DW)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .shift_en (in_valid),
    .din      (x_now),
    .hist     (hist)
  );

  always_comb begin
    s_prev_d    = s_prev_q;
    outp_d      = outp_q;
    out_valid_d = 1'b0;
    cnt_d       = cnt_q;
    if (in_valid) begin
      outp_d      = x_now;
      out_valid_d = 1'b1;
      s_prev_d    = inp;
      if (cnt_q != CNT_FULL) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // primed tracks the counter value being written this edge.
    primed_d = (cnt_d == CNT_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev_q    <= '0;
      outp_q      <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      primed_q    <= 1'b0;
    end else begin
      s_prev_q    <= s_prev_d;
      outp_q      <= outp_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
    end
  end

  assign outp      = outp_q;
  assign out_valid = out_valid_q;
  assign primed    = primed_q;

endmodule : past_sequence_recover

// File: tb/tb_past_sequence_recover.sv
// Bench for past_sequence_recover: N=4 and N=1 instances share one input
// stream and are checked against a window-sum reference model.
module tb_past_sequence_recover;

  localparam int DW = 8;
  localparam int N4 = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] inp;

  logic          out_valid4, primed4;
  logic [DW-1:0] outp4;
  logic          out_valid1, primed1;
  logic [DW-1:0] outp1;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [DW-1:0] x4_q[$];     // last N4-1 recovered samples, newest first
  logic [DW-1:0] win_q[$];    // upstream adder window, newest first
  logic [DW-1:0] exp_q[$];    // expected outp for the N=4 instance
  logic [DW-1:0] exp1_q[$];   // expected outp for the N=1 instance
  logic [DW-1:0] hold4, hold1;
  int            cnt4, cnt1;

  always #5 clk = ~clk;

  past_sequence_recover #(.N(N4), .DW(DW)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .inp       (inp),
    .out_valid (out_valid4),
    .outp      (outp4),
    .primed    (primed4)
  );

  past_sequence_recover #(.N(1), .DW(DW)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .inp       (inp),
    .out_valid (out_valid1),
    .outp      (outp1),
    .primed    (primed1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    x4_q  = '{8'd0, 8'd0, 8'd0};
    cnt4  = 0;
    cnt1  = 0;
    hold4 = '0;
    hold1 = '0;
  endtask

  task automatic adder_clear();
    win_q = '{8'd0, 8'd0, 8'd0, 8'd0};
  endtask

  // Push a raw sample into the adder model and return the window sum.
  task automatic adder_push(input logic [DW-1:0] x, output logic [DW-1:0] s);
    int acc;
    win_q.push_front(x);
    void'(win_q.pop_back());
    acc = 0;
    foreach (win_q[i]) acc += int'(win_q[i]);
    s = acc[DW-1:0];
  endtask

  // Drive one cycle starting at a falling edge; check just after the next rising edge.
  task automatic drive(input bit r, input bit v, input logic [DW-1:0] s);
    int            acc;
    logic [DW-1:0] x;
    bit            ev;
    rst      = r;
    in_valid = v;
    inp      = s;
    @(posedge clk);
    #1;
    ev = 1'b0;
    if (r) begin
      model_clear();
    end else if (v) begin
      // the sample is whatever completes the window sum given the previous N-1
      acc = 0;
      foreach (x4_q[i]) acc += int'(x4_q[i]);
      x = s - acc[DW-1:0];
      x4_q.push_front(x);
      void'(x4_q.pop_back());
      if (cnt4 < N4) cnt4++;
      cnt1  = 1;
      hold4 = x;
      hold1 = s;
      exp_q.push_back(x);
      exp1_q.push_back(s);
      ev = 1'b1;
    end
    check("out_valid4", 32'(out_valid4), 32'(ev));
    check("out_valid1", 32'(out_valid1), 32'(ev));
    if (ev) begin
      check("outp4", 32'(outp4), 32'(exp_q.pop_front()));
      check("outp1", 32'(outp1), 32'(exp1_q.pop_front()));
    end else begin
      check("outp4_hold", 32'(outp4), 32'(hold4));
      check("outp1_hold", 32'(outp1), 32'(hold1));
    end
    check("primed4", 32'(primed4), 32'(cnt4 == N4));
    check("primed1", 32'(primed1), 32'(cnt1 == 1));
    @(negedge clk);
  endtask

  task automatic send_sample(input logic [DW-1:0] x);
    logic [DW-1:0] s;
    adder_push(x, s);
    drive(1'b0, 1'b1, s);
  endtask

  initial begin
    logic [DW-1:0] s;
    bit            r, v;
    rst      = 1'b1;
    in_valid = 1'b0;
    inp      = '0;
    model_clear();
    adder_clear();
    @(negedge clk);

    // reset state
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 8'd0);

    // counter loopback with a 3-cycle gap after the sum of 0..3
    for (int i = 0; i < 4; i++) send_sample(8'(i));
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'($urandom_range(0, 255)));
    for (int i = 4; i < 12; i++) send_sample(8'(i));

    // wrap-around: counter 250..255,0..5 from zero history
    drive(1'b1, 1'b0, 8'd0);
    adder_clear();
    for (int i = 250; i < 262; i++) send_sample(8'(i));

    // reset mid-stream with a valid sum that must be dropped, then constant sums
    drive(1'b1, 1'b1, 8'd10);
    adder_clear();
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 8'd7);

    // N=1 pass-through values
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b0, 1'b1, 8'h3C);
    drive(1'b0, 1'b1, 8'hFF);
    drive(1'b0, 1'b1, 8'h01);

    // randomized: mixture of genuine adder sums, arbitrary sums, gaps and resets
    drive(1'b1, 1'b0, 8'd0);
    adder_clear();
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 3) != 0);
      if (v && !r && $urandom_range(0, 3) != 0) begin
        adder_push(8'($urandom_range(0, 255)), s);
      end else begin
        s = 8'($urandom_range(0, 255));
      end
      if (r) adder_clear();
      drive(r, v, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_past_sequence_recover

// File: doc/past_sequence_recover.md
# past_sequence_recover

Inverse of `past_sequence_adder`: it takes the stream of N-sample window sums produced by the adder and reconstructs the original input samples. It sits at the receiving end of an adder link and is used in loopback benches (counter → `past_sequence_adder` → `past_sequence_recover` → compare). It is also used wherever a downstream stage needs the raw samples back from a summed stream. Recovery uses x[t] = S[t] − S[t−1] + x[t−N], modulo 2^DW.

## Interface
- `N`, 4, window length of the upstream adder; N ≥ 1.
- `DW`, 8, sample and sum width in bits.

- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `inp` carries a new window sum this cycle.
- `inp` input DW: window sum S[t] from the adder.
- `out_valid` output 1: `outp` holds a newly recovered sample. High for exactly one cycle per accepted input.
- `outp` output DW: recovered sample x[t].
- `primed` output 1: high once N samples have been accepted since reset. From then on, every recovered value depends only on post-reset data.

## Operation
- Contract: the first sum accepted after reset corresponds to an adder window whose earlier N−1 entries were zero. This is the same zero-history start as the adder.
- Internal state:
  - `s_prev` (DW): last accepted sum.
  - `hist[0..N−1]` (DW each): last N recovered samples; `hist[N−1]` = x[t−N].
  - `cnt`: accepted-sample counter, 0..N, saturating at N.
- On an accepted cycle (`in_valid`=1, `rst`=0):
  - x = inp − s_prev + hist[N−1], truncated to DW bits. All arithmetic wraps mod 2^DW; no overflow flag.
  - `outp` ← x and `out_valid` ← 1.
  - `s_prev` ← inp.
  - hist shifts: hist[0] ← x and hist[k] ← hist[k−1].
  - `cnt` ← min(cnt+1, N).
- When `in_valid`=0: `out_valid` ← 0. `outp`, `s_prev`, hist and `cnt` all hold, so input gaps are transparent.
- N=1: hist[0] is x[t−1], and the recovery reduces to x = inp. The same equations hold without a special case.
- `primed` = (cnt == N), registered.

## Timing
- Latency is 1 cycle: a sum accepted at edge k appears on `outp` with `out_valid`=1 after edge k. No bubbles are inserted, so full throughput is one sample per cycle.
- Reset values: `outp`=0, `out_valid`=0, `primed`=0, `s_prev`=0, all hist=0, `cnt`=0.
- `rst` has priority over `in_valid` in the same cycle; the input is dropped.
- Reset mid-stream clears all history. The upstream adder must restart from zero history at the same point, or recovered values are wrong until the garbage window drains. That period is at most N accepted samples, and `primed` reflects it.
- There is no backpressure; the consumer must accept every `out_valid` pulse.

## Structure
- No shared package types are needed. `N`/`DW` defaults come from the same parameter set the adder uses, so the pair always matches.
- One sub-module: `sample_history`, an N-deep, DW-wide shift register with shift-enable and synchronous clear. It is reusable by the adder side.
- The top level holds `s_prev`, the subtract/add datapath, the `cnt`/`primed` logic and the output registers.

## Test plan
- **Counter loopback:** defaults N=4, DW=8. Feed the counter 0,1,2,… through `past_sequence_adder` with zero history, giving sums 0,1,3,6,10,14,… → `outp` = 0,1,2,3,4,5,… one cycle later. `primed` rises after the 4th accepted sum.
- **Wrap-around:** the counter runs 250..255,0..5, and the sums wrap mod 256 (e.g. 253+254+255+0 = 762 → 250) → `outp` = 255,0,1,… exactly, with no glitch.
- **Valid gaps:** insert `in_valid`=0 for 3 cycles between sums 6 and 10 → `out_valid` low for those cycles, `outp` holds 3, and the next pulse gives 4.
- **Reset mid-stream:** assert `rst` for 1 cycle with `in_valid`=1 and sum 10. Then the adder restarts from zero and feeds sums 7,7,7,7,… (constant 7 input) → `outp` = 7,0,0,0,7,0,… Also check `cnt` and `primed` clear, and that the dropped input produces no `out_valid`.
- **N=1:** set N=1, DW=8 and feed arbitrary inp 0x3C, 0xFF, 0x01 → `outp` equals inp with 1-cycle latency, and `primed` is high after the first accepted sum.
